// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the YetAnotherUART transmitter and register map.
package uart_pkg;
   localparam int UART_TX_BYTE_W  = 8;
   localparam int UART_BAUD_DIV_W = 16;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

   typedef enum logic [1:0] {UART_DB_5, UART_DB_6, UART_DB_7, UART_DB_8} uart_data_bits_t;

   typedef struct packed {
      logic [UART_BAUD_DIV_W-1:0] div;
      uart_data_bits_t            data_bits;
      logic                       parity_en;
      logic                       parity_odd;
      logic                       stop2;
   } uart_tx_cfg_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: reloadable bit-period counter; o_bit_end marks the last clock of each bit.
module uart_baud_gen #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [DIV_WIDTH-1:0] i_div,
   output logic                 o_bit_end
);
   logic [DIV_WIDTH-1:0] r_cnt;

   assign o_bit_end = r_cnt == i_div;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_cnt <= '0;
      else r_cnt <= (i_start || o_bit_end) ? '0 : r_cnt + 1'b1;
   end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: YetAnotherUART serializer, LSB first, configuration latched per frame.
// Define UART_TX_PARITY_EN to build the optional parity bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV_WIDTH = UART_BAUD_DIV_W
) (
   input  logic                      i_apb_pclk,
   input  logic                      i_apb_presetn,
   input  logic                      i_enable,
   input  logic [BAUD_DIV_WIDTH-1:0] i_baud_div,
   input  logic [1:0]                i_data_bits,
   input  logic                      i_parity_en,
   input  logic                      i_parity_odd,
   input  logic                      i_stop2,
   input  logic [UART_TX_BYTE_W-1:0] i_tx_data,
   input  logic                      i_tx_valid,
   output logic                      o_tx_ready,
   output logic                      o_txd,
   output logic                      o_busy,
   output logic                      o_done
);
   uart_tx_state_t            r_state;
   uart_tx_cfg_t              r_cfg;
   logic [UART_TX_BYTE_W-1:0] r_shift;
   logic [2:0]                r_bit_cnt;
   logic                      r_stop_cnt;
   logic                      r_txd;
   logic                      r_busy;
   logic                      w_bit_end;
   logic                      w_last;
   logic                      w_accept;
`ifdef UART_TX_PARITY_EN
   logic                      r_par;
`else
   logic                      w_unused;
   assign w_unused = r_cfg.parity_en ^ r_cfg.parity_odd;
`endif

   assign w_last     = r_state == STOP && w_bit_end && r_stop_cnt == r_cfg.stop2;
   assign o_tx_ready = i_enable && (r_state == IDLE || w_last);
   assign w_accept   = i_tx_valid && o_tx_ready;
   assign o_done     = w_last;
   assign o_txd      = r_txd;
   assign o_busy     = r_busy;

   uart_baud_gen #(
      .DIV_WIDTH(BAUD_DIV_WIDTH)
   ) u_baud (
      .i_clk    (i_apb_pclk),
      .i_rst_n  (i_apb_presetn),
      .i_start  (w_accept),
      .i_div    (BAUD_DIV_WIDTH'(r_cfg.div)),
      .o_bit_end(w_bit_end)
   );

   // r_txd always holds the level of the bit being sent, loaded one edge ahead.
   always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
      if (!i_apb_presetn) begin
         r_state    <= IDLE;
         r_cfg      <= '0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_txd      <= 1'b1;
         r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par      <= 1'b0;
`endif
      end else if (w_accept) begin
         r_state    <= START;
         r_cfg      <= '{div: UART_BAUD_DIV_W'(i_baud_div), data_bits: uart_data_bits_t'(i_data_bits),
                         parity_en: i_parity_en, parity_odd: i_parity_odd, stop2: i_stop2};
         r_shift    <= i_tx_data;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_txd      <= 1'b0;
         r_busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par      <= i_parity_odd;
`endif
      end else if (w_bit_end) begin
         case (r_state)
            START: begin
               r_state <= DATA;
               r_txd   <= r_shift[0];
            end
            DATA: begin
               r_shift <= r_shift >> 1;
`ifdef UART_TX_PARITY_EN
               r_par   <= r_par ^ r_shift[0];
`endif
               if (r_bit_cnt == 3'd4 + 3'(r_cfg.data_bits)) begin
                  r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                  r_state   <= r_cfg.parity_en ? PARITY : STOP;
                  r_txd     <= r_cfg.parity_en ? r_par ^ r_shift[0] : 1'b1;
`else
                  r_state   <= STOP;
                  r_txd     <= 1'b1;
`endif
               end else begin
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  r_txd     <= r_shift[1];
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               r_state <= STOP;
               r_txd   <= 1'b1;
            end
`endif
            STOP: begin
               if (r_stop_cnt != r_cfg.stop2) begin
                  r_stop_cnt <= 1'b1;
               end else begin
                  r_state    <= IDLE;
                  r_stop_cnt <= 1'b0;
                  r_busy     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames with hand-computed line waveforms for uart_tx.
module tb_uart_tx;
   logic        i_apb_pclk = 1'b0;
   logic        i_apb_presetn;
   logic        i_enable;
   logic [15:0] i_baud_div;
   logic [1:0]  i_data_bits;
   logic        i_parity_en;
   logic        i_parity_odd;
   logic        i_stop2;
   logic [7:0]  i_tx_data;
   logic        i_tx_valid;
   logic        o_tx_ready;
   logic        o_txd;
   logic        o_busy;
   logic        o_done;
   int          n_chk = 0;
   int          n_err = 0;

   uart_tx dut (
      .i_apb_pclk   (i_apb_pclk),
      .i_apb_presetn(i_apb_presetn),
      .i_enable     (i_enable),
      .i_baud_div   (i_baud_div),
      .i_data_bits  (i_data_bits),
      .i_parity_en  (i_parity_en),
      .i_parity_odd (i_parity_odd),
      .i_stop2      (i_stop2),
      .i_tx_data    (i_tx_data),
      .i_tx_valid   (i_tx_valid),
      .o_tx_ready   (o_tx_ready),
      .o_txd        (o_txd),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 i_apb_pclk = ~i_apb_pclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // seq[0] is the first bit on the line; each bit is stretched to div+1 clocks
   function automatic logic [63:0] expand(input logic [15:0] seq, input int nb, input int div);
      logic [63:0] w = '0;
      int p = 0;
      for (int i = 0; i < nb; i++)
         for (int j = 0; j <= div; j++) begin
            w[p] = seq[i];
            p++;
         end
      return w;
   endfunction

   task automatic wait_ready();
      int n = 0;
      @(negedge i_apb_pclk);
      while (!o_tx_ready && n < 200) begin
         @(negedge i_apb_pclk);
         n++;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [15:0] div, input logic [1:0] db,
                       input logic pe, input logic po, input logic s2, input int mid_k,
                       output logic [63:0] wave, output int len);
      i_baud_div = div; i_data_bits = db; i_parity_en = pe; i_parity_odd = po; i_stop2 = s2;
      i_tx_data = d; i_tx_valid = 1'b1;
      wave = '0; len = 0;
      wait_ready();
      check("accept_ready", o_tx_ready, 1);
      @(posedge i_apb_pclk);
      #1 i_tx_valid = 1'b0;
      i_tx_data = ~d;
      for (int k = 0; k < 64; k++) begin
         @(negedge i_apb_pclk);
         wave[k] = o_txd;
         if (k == mid_k) begin
            i_enable = 1'b0; i_baud_div = 16'd7; i_data_bits = 2'd0; i_stop2 = 1'b1; i_tx_valid = 1'b1;
         end
         if (o_done) begin
            len = k + 1;
            break;
         end
      end
   endtask

   initial begin
      logic [63:0] wave;
      int          len;
      int          a2;
      int          nrdy;
      int          bad;
      logic        d2;
      i_apb_presetn = 1'b0; i_enable = 1'b0; i_baud_div = '0; i_data_bits = '0;
      i_parity_en = 1'b0; i_parity_odd = 1'b0; i_stop2 = 1'b0; i_tx_data = '0; i_tx_valid = 1'b0;
      #12;
      check("rst_txd", o_txd, 1);
      check("rst_ready", o_tx_ready, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      @(posedge i_apb_pclk);
      #1 i_apb_presetn = 1'b1;
      i_enable = 1'b1;
      @(negedge i_apb_pclk);
      check("idle_ready", o_tx_ready, 1);

      send(8'hA5, 16'd3, 2'd3, 1'b0, 1'b0, 1'b0, -1, wave, len);
      check("8n1_wave", wave, expand(16'b1101001010, 10, 3));
      check("8n1_len", len, 40);
`ifdef UART_TX_PARITY_EN
      send(8'h53, 16'd1, 2'd2, 1'b1, 1'b0, 1'b1, -1, wave, len);
      check("7e2_wave", wave, expand(16'b11010100110, 11, 1));
      check("7e2_len", len, 22);
      send(8'hFF, 16'd0, 2'd0, 1'b1, 1'b1, 1'b0, -1, wave, len);
      check("5o1_wave", wave, expand(16'b10111110, 8, 0));
      check("5o1_len", len, 8);
`else
      send(8'h53, 16'd1, 2'd2, 1'b1, 1'b0, 1'b1, -1, wave, len);
      check("7e2_wave", wave, expand(16'b1110100110, 10, 1));
      check("7e2_len", len, 20);
      send(8'hFF, 16'd0, 2'd0, 1'b1, 1'b1, 1'b0, -1, wave, len);
      check("5o1_wave", wave, expand(16'b1111110, 7, 0));
      check("5o1_len", len, 7);
`endif

      i_baud_div = 16'd2; i_data_bits = 2'd3; i_parity_en = 1'b0; i_stop2 = 1'b0;
      i_tx_data = 8'h00; i_tx_valid = 1'b1;
      wait_ready();
      check("b2b_ready1", o_tx_ready, 1);
      @(posedge i_apb_pclk);
      #1 i_tx_data = 8'hFF;
      wave = '0; a2 = 0; d2 = 1'b0; nrdy = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge i_apb_pclk);
         wave[k] = o_txd;
         if (o_tx_ready) begin
            nrdy++;
            if (a2 == 0) begin
               a2 = k + 1;
               d2 = o_done;
               @(posedge i_apb_pclk);
               #1 i_tx_valid = 1'b0;
            end
         end
      end
      check("b2b_gap", a2, 30);
      check("b2b_done", d2, 1);
      check("b2b_nready", nrdy, 2);
      check("b2b_wave", wave, expand(16'b1000000000, 10, 2) | (expand(16'b1111111110, 10, 2) << 30));

      send(8'h96, 16'd1, 2'd3, 1'b0, 1'b0, 1'b0, 6, wave, len);
      check("dis_wave", wave, expand(16'b1100101100, 10, 1));
      check("dis_len", len, 20);
      bad = 0;
      repeat (10) begin
         @(negedge i_apb_pclk);
         if (o_tx_ready || !o_txd || o_busy) bad++;
      end
      check("dis_idle", bad, 0);
      i_tx_valid = 1'b0;
      i_enable = 1'b1;

      i_baud_div = 16'd1; i_data_bits = 2'd3; i_stop2 = 1'b0; i_tx_data = 8'h00; i_tx_valid = 1'b1;
      wait_ready();
      @(posedge i_apb_pclk);
      #1 i_tx_valid = 1'b0;
      repeat (7) @(negedge i_apb_pclk);
      check("pre_rst_txd", o_txd, 0);
      #2 i_apb_presetn = 1'b0;
      #1;
      check("mid_rst_txd", o_txd, 1);
      check("mid_rst_busy", o_busy, 0);
      @(posedge i_apb_pclk);
      #1 i_apb_presetn = 1'b1;
      send(8'h3C, 16'd1, 2'd3, 1'b0, 1'b0, 1'b0, -1, wave, len);
      check("post_rst_wave", wave, expand(16'b1001111000, 10, 1));
      check("post_rst_len", len, 20);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for YetAnotherUART, directly downstream of the APB3 register map. It takes frame configuration (baud divisor, data length, parity, stop bits) from the `uart_regmap_t` fields and bytes from the TX data path through a valid/ready handshake. It serializes each byte LSB-first onto `o_txd` with start, optional parity and stop bits. Configuration is latched per frame, so register writes never corrupt a frame in flight.

## Interface
- `BAUD_DIV_WIDTH`, default 16: width of the baud divisor.
- `i_apb_pclk`  in  1  single clock; all logic is on the rising edge.
- `i_apb_presetn`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  transmitter enable (from REGMAP_OUT).
- `i_baud_div`  in  BAUD_DIV_WIDTH  bit period minus one, in clocks.
- `i_data_bits`  in  2  data length: 0..3 maps to 5..8 bits.
- `i_parity_en`  in  1  parity bit enable.
- `i_parity_odd`  in  1  1 = odd parity, 0 = even.
- `i_stop2`  in  1  1 = two stop bits, 0 = one.
- `i_tx_data`  in  8  byte to send. Bits above the data length are ignored.
- `i_tx_valid`  in  1  upstream has a byte.
- `o_tx_ready`  out  1  the block accepts `i_tx_data` this cycle.
- `o_txd`  out  1  serial line; idle high.
- `o_busy`  out  1  a frame is in progress.
- `o_done`  out  1  one-cycle pulse in the final cycle of a frame.

## Operation
- FSM `uart_tx_state_t` has the states IDLE, START, DATA, PARITY and STOP.
- **Accept.** A byte is accepted on any cycle where `i_tx_valid && o_tx_ready`.
  - On accept, latch the data byte, `i_baud_div`, the data length, parity enable/odd and `i_stop2`.
  - Load the shift register with the byte and go to START.
- **Ready.** `o_tx_ready = i_enable && (state==IDLE || last_cycle_of_frame)`.
- **START.** `o_txd=0` for one bit period, then go to DATA.
- **DATA.** `o_txd` = shift register bit 0, LSB first.
  - Shift right at the end of each bit.
  - The bit counter counts from 0 to N-1, with N = 5 + latched data_bits.
  - After bit N-1, go to PARITY if parity is enabled, otherwise to STOP.
- **PARITY.** `o_txd` = XOR of the N data bits, XOR `parity_odd`. Lasts one bit period, then go to STOP.
- **STOP.** `o_txd=1` for one bit period, or two bit periods when `stop2` is set.
- **End of STOP.**
  - If a byte was accepted in that final cycle, go to START.
  - Otherwise go to IDLE.
- **Bit period.** A bit lasts `latched_div+1` clocks.
  - The baud counter reloads to 0 at each bit boundary.
  - `i_baud_div=0` gives one clock per bit.
- **Parity** is computed over the latched byte masked to N bits. A 9-bit accumulator or a running XOR of the shifted bits are both acceptable.
- **`o_busy`** is 1 in every state except IDLE.
- **Enable low.**
  - Dropping `i_enable` mid-frame does not abort the frame. The frame completes.
  - No new byte is accepted while `i_enable` is low, and the block then returns to IDLE.
- **Configuration changes mid-frame** have no effect until the next accept.
- **Upstream data** is not required to be stable after the accept cycle.

## Timing
- **Reset values:**
  - `o_txd` = 1
  - `o_tx_ready` = 0 (then follows `i_enable` in IDLE)
  - `o_busy` = 0
  - `o_done` = 0
  - FSM in IDLE, all counters at 0.
- **Reset mid-frame:** `o_txd` returns high asynchronously and the frame is dropped.
- `o_txd` is driven from a flop, with no combinational path from any input.
- **Latency:** if a byte is accepted at cycle t, the start bit's falling edge appears on `o_txd` at cycle t+1.
- **Frame length:** `(div+1) * (1 + N + P + S)` clocks, with P in {0,1} and S in {1,2}.
- **`o_done`:** high exactly in the last clock of the last stop bit. `o_tx_ready` is also high in that clock when `i_enable=1`.
- **Back-to-back frames** have no idle gap: the next start bit begins the clock after the previous stop bit ends.

## Configuration
- The macro is `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state and the parity logic are present, and behave as described above.
- **Undefined:**
  - The PARITY state is not synthesized, and `i_parity_en`/`i_parity_odd` are ignored.
  - P is always 0, and DATA goes straight to STOP.

## Structure
- **`uart_pkg` contents:**
  - The `uart_tx_state_t` enum.
  - The `uart_data_bits_t` enum (`UART_DB_5..UART_DB_8` = 0..3).
  - The localparam `UART_TX_BYTE_W = 8`.
  - A `uart_tx_cfg_t` struct {div, data_bits, parity_en, parity_odd, stop2}, used for the latched configuration and shared with the register map.
- **Sub-module `uart_baud_gen`:**
  - Loadable divisor counter.
  - Takes inputs `start` (reload) and `div`.
  - Outputs a `bit_end` pulse in the last clock of each bit period.
  - The FSM advances only on `bit_end`.

## Test plan
- **8N1, div=3:** send 0xA5. `o_txd` reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks, 40 clocks in total. `o_done` pulses at clock 40 after accept.
- **7E2, div=1, parity enabled (even):** send 0x53. Data bits are 1,1,0,0,1,0,1, parity is 0, followed by two stop bits. The frame is 22 clocks.
- **5O1, div=0:** send 0xFF (masked to 0x1F). Data is 1,1,1,1,1, parity is 0, and the frame is 8 clocks.
  - With `UART_TX_PARITY_EN` undefined, the same stimulus gives a 7-clock frame with no parity bit.
- **Back-to-back, div=2, 8N1:** send 0x00 then 0xFF with `i_tx_valid` held high. The second start bit begins exactly 30 clocks after the first, and `o_tx_ready` pulses in the final clock of each frame.
- **Enable/config mid-frame:** deassert `i_enable` and change `i_baud_div` during the data bits. The current frame completes with the old divisor, then `o_tx_ready` stays 0 and `o_txd` stays 1.
- **Reset mid-frame:** assert `i_apb_presetn=0` during DATA. `o_txd`=1 and `o_busy`=0 immediately, without waiting for a clock edge. After release, a new 0x3C frame transmits correctly.
